// File: rtl/dread.sv
// SDRAM readback engine: issues word reads, tracks in-flight returns and forwards data to the host FIFO.
// Optional abort input enabled by defining DREAD_ABORT_EN.
module dread #(
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic        sdram_clk,
    input  logic        sdram_rst,
    input  logic        rd_start,
    input  logic [31:0] rd_start_addr,
    input  logic [31:0] rd_depth,
    input  logic [31:0] sample_last_cnt,
`ifdef DREAD_ABORT_EN
    input  logic        rd_abort,
`endif
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic        rd_valid,
    input  logic        rd_data_valid,
    input  logic [15:0] rd_data,
    output logic [15:0] rfifo_din,
    output logic        rfifo_wr_en,
    input  logic        rfifo_prog_full,
    output logic        rd_busy,
    output logic        rd_done,
    output logic        rd_err
);

    localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic [31:0] remaining_r;
    logic [31:0] remaining_nx_s;
    logic [31:0] addr_nx_s;
    logic [3:0]  outstanding_r;
    logic [3:0]  outstanding_nx_s;
    logic        start_acc_s;
    logic        accept_s;
    logic        abort_s;
    logic        spurious_s;
    logic        wrap_s;
    logic        req_nx_s;

`ifdef DREAD_ABORT_EN
    assign abort_s = rd_abort & (state_r == ST_REQ);
`else
    assign abort_s = 1'b0;
`endif

    assign start_acc_s = rd_start & (state_r == ST_IDLE);
    assign accept_s    = rd_req & rd_valid;
    assign spurious_s  = rd_data_valid & (outstanding_r == 4'd0);
    assign wrap_s      = ({2'b00, rd_addr[31:2]} == sample_last_cnt);

    // Next-state selection for the readback sequencer
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rd_start) begin
                    state_nx_s = (rd_depth == 32'd0) ? ST_DONE : ST_REQ;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (abort_s) begin
                    state_nx_s = ST_DRAIN;
                end else if (accept_s && (remaining_r == 32'd1)) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_REQ;
                end
            end
            ST_DRAIN: begin
                // A return landing this cycle still has to be forwarded before completion
                if ((outstanding_r == 4'd0) && !rd_data_valid) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Next values of the address, remaining and in-flight counters
    always_comb begin
        remaining_nx_s   = remaining_r;
        addr_nx_s        = rd_addr;
        outstanding_nx_s = outstanding_r;

        if (start_acc_s) begin
            remaining_nx_s = rd_depth;
            addr_nx_s      = rd_start_addr & 32'hFFFF_FFFC;
        end else if (abort_s) begin
            remaining_nx_s = 32'd0;
            addr_nx_s      = accept_s ? (wrap_s ? 32'd0 : rd_addr + 32'd4) : rd_addr;
        end else if (accept_s) begin
            remaining_nx_s = (remaining_r != 32'd0) ? remaining_r - 32'd1 : 32'd0;
            addr_nx_s      = wrap_s ? 32'd0 : rd_addr + 32'd4;
        end else begin
            remaining_nx_s = remaining_r;
            addr_nx_s      = rd_addr;
        end

        case ({accept_s, rd_data_valid})
            2'b10:   outstanding_nx_s = outstanding_r + 4'd1;
            2'b01:   outstanding_nx_s = (outstanding_r == 4'd0) ? 4'd0 : outstanding_r - 4'd1;
            default: outstanding_nx_s = outstanding_r;
        endcase

        req_nx_s = (state_nx_s == ST_REQ) & ~rfifo_prog_full & (outstanding_nx_s < MAX_OUT_C);
    end

    // Sequencer state and counters
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            state_r       <= ST_IDLE;
            remaining_r   <= 32'd0;
            outstanding_r <= 4'd0;
            rd_addr       <= 32'd0;
        end else begin
            state_r       <= state_nx_s;
            remaining_r   <= remaining_nx_s;
            outstanding_r <= outstanding_nx_s;
            rd_addr       <= addr_nx_s;
        end
    end

    // Registered status, request and FIFO-forwarding outputs
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            rd_req      <= 1'b0;
            rd_busy     <= 1'b0;
            rd_done     <= 1'b0;
            rd_err      <= 1'b0;
            rfifo_din   <= 16'd0;
            rfifo_wr_en <= 1'b0;
        end else begin
            rd_req      <= req_nx_s;
            rd_busy     <= (state_nx_s != ST_IDLE);
            rd_done     <= (state_r == ST_DONE);
            rfifo_din   <= rd_data;
            rfifo_wr_en <= rd_data_valid;
            // A stray return wins over a same-cycle start so it is never lost
            if (spurious_s) begin
                rd_err <= 1'b1;
            end else if (start_acc_s) begin
                rd_err <= 1'b0;
            end else begin
                rd_err <= rd_err;
            end
        end
    end

endmodule

// File: tb/tb_dread.sv
// Scoreboard bench for dread: an SDRAM responder model feeds returns and the
// expected addresses/FIFO words are queued at stimulus time and popped on DUT output.
module tb_dread;

    localparam int MAX_OUT = 8;

    logic        sdram_clk = 1'b0;
    logic        sdram_rst = 1'b1;
    logic        rd_start = 1'b0;
    logic [31:0] rd_start_addr = 32'd0;
    logic [31:0] rd_depth = 32'd0;
    logic [31:0] sample_last_cnt = 32'd1023;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_valid = 1'b0;
    logic        rd_data_valid = 1'b0;
    logic [15:0] rd_data = 16'd0;
    logic [15:0] rfifo_din;
    logic        rfifo_wr_en;
    logic        rfifo_prog_full = 1'b0;
    logic        rd_busy;
    logic        rd_done;
    logic        rd_err;

    dread #(.MAX_OUTSTANDING(MAX_OUT)) dut (
        .sdram_clk       (sdram_clk),
        .sdram_rst       (sdram_rst),
        .rd_start        (rd_start),
        .rd_start_addr   (rd_start_addr),
        .rd_depth        (rd_depth),
        .sample_last_cnt (sample_last_cnt),
        .rd_req          (rd_req),
        .rd_addr         (rd_addr),
        .rd_valid        (rd_valid),
        .rd_data_valid   (rd_data_valid),
        .rd_data         (rd_data),
        .rfifo_din       (rfifo_din),
        .rfifo_wr_en     (rfifo_wr_en),
        .rfifo_prog_full (rfifo_prog_full),
        .rd_busy         (rd_busy),
        .rd_done         (rd_done),
        .rd_err          (rd_err)
    );

    always #5 sdram_clk = ~sdram_clk;

    int cyc = 0;
    always @(posedge sdram_clk) cyc <= cyc + 1;

    typedef struct {int due; logic [15:0] d;} ret_t;
    typedef struct {int c; logic [15:0] d;} exp_t;

    ret_t        ret_q[$];
    exp_t        exp_data[$];
    logic [31:0] exp_addr[$];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int last_done_cyc = -1;
    int wr_cnt = 0;
    int acc_cnt = 0;
    int model_out = 0;
    int peak_out = 0;
    int lat = 3;
    int last_due = 0;
    int start_cyc = 0;
    bit rv_rand = 1'b0;
    bit req_seen = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_rd(input logic [31:0] a, input logic [31:0] d, input logic [31:0] l);
        logic [31:0] x;
        x = a & 32'hFFFF_FFFC;
        for (int i = 0; i < int'(d); i++) begin
            exp_addr.push_back(x);
            x = ({2'b00, x[31:2]} == l) ? 32'd0 : x + 32'd4;
        end
        rd_start_addr   = a;
        rd_depth        = d;
        sample_last_cnt = l;
        rd_start        = 1'b1;
        start_cyc       = cyc;
        @(posedge sdram_clk);
        #1 rd_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base;
        base = done_cnt;
        for (int i = 0; i < budget && done_cnt == base; i++) begin
            @(posedge sdram_clk);
            #1;
        end
        check_val(tag, 32'(done_cnt - base), 32'd1);
        check_val("addr_left", 32'(exp_addr.size()), 32'd0);
        check_val("busy_after_done", 32'(rd_busy), 32'd0);
        check_val("done_pulse_width", 32'(rd_done), 32'd0);
        exp_addr.delete();
    endtask

    // SDRAM responder and output monitor, sampled on the falling edge
    initial begin
        exp_t e;
        ret_t r;
        forever begin
            @(negedge sdram_clk);
            if (rd_done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (rfifo_wr_en) begin
                check_val("wr_q_nonempty", 32'(exp_data.size() != 0), 32'd1);
                if (exp_data.size() != 0) begin
                    e = exp_data.pop_front();
                    check_val("rfifo_din", 32'(rfifo_din), 32'(e.d));
                    check_val("wr_latency", 32'(cyc), 32'(e.c + 1));
                end
                wr_cnt++;
            end
            if (rd_req) req_seen = 1'b1;
            if (model_out == MAX_OUT) check_val("req_at_max", 32'(rd_req), 32'd0);
            if (model_out > peak_out) peak_out = model_out;
            rd_valid = rv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_req && rd_valid) begin
                check_val("addr_q_nonempty", 32'(exp_addr.size() != 0), 32'd1);
                if (exp_addr.size() != 0) check_val("rd_addr", rd_addr, exp_addr.pop_front());
                r.due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                last_due = r.due;
                r.d = rd_addr[17:2] ^ 16'h5A3C;
                ret_q.push_back(r);
                model_out++;
                acc_cnt++;
            end
            if (ret_q.size() != 0 && ret_q[0].due <= cyc) begin
                r = ret_q.pop_front();
                rd_data_valid = 1'b1;
                rd_data = r.d;
                if (!sdram_rst) begin
                    e.c = cyc;
                    e.d = r.d;
                    exp_data.push_back(e);
                end
                if (model_out > 0) model_out--;
            end else begin
                rd_data_valid = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int wb;
        int ab;
        int ab2;
        int db;
        int s;
        ret_t sp;

        repeat (3) @(posedge sdram_clk);
        #1;
        check_val("rst_rd_req", 32'(rd_req), 32'd0);
        check_val("rst_rd_addr", rd_addr, 32'd0);
        check_val("rst_wr_en", 32'(rfifo_wr_en), 32'd0);
        check_val("rst_din", 32'(rfifo_din), 32'd0);
        check_val("rst_busy", 32'(rd_busy), 32'd0);
        check_val("rst_done", 32'(rd_done), 32'd0);
        check_val("rst_err", 32'(rd_err), 32'd0);
        sdram_rst = 1'b0;
        @(posedge sdram_clk);
        #1;

        // basic four-word readback
        lat = 3;
        wb = wr_cnt;
        start_rd(32'h100, 32'd4, 32'd1023);
        check_val("busy_after_start", 32'(rd_busy), 32'd1);
        wait_done("done_basic", 100);
        check_val("wr_count_basic", 32'(wr_cnt - wb), 32'd4);

        // wrap at the top of the sample window, with irregular accepts
        rv_rand = 1'b1;
        start_rd(32'hFF8, 32'd4, 32'd1023);
        wait_done("done_wrap", 200);
        rv_rand = 1'b0;
        start_rd(32'h13, 32'd5, 32'd5);
        wait_done("done_wrap_small", 100);

        // zero-length readback
        ab = acc_cnt;
        req_seen = 1'b0;
        start_rd(32'h40, 32'd0, 32'd1023);
        s = start_cyc;
        wait_done("done_zero", 20);
        check_val("zero_done_latency", 32'(last_done_cyc - s), 32'd2);
        check_val("zero_no_req", 32'(req_seen), 32'd0);
        check_val("zero_no_accept", 32'(acc_cnt - ab), 32'd0);

        // long latency: outstanding limit and host back-pressure
        lat = 20;
        wb = wr_cnt;
        ab = acc_cnt;
        peak_out = 0;
        start_rd(32'h4000, 32'd32, 32'd1023);
        for (int i = 0; i < 200 && (acc_cnt - ab) < 10; i++) begin
            @(posedge sdram_clk);
            #1;
        end
        rfifo_prog_full = 1'b1;
        @(posedge sdram_clk);
        #1;
        check_val("pf_stop", 32'(rd_req), 32'd0);
        ab2 = acc_cnt;
        repeat (6) begin
            @(posedge sdram_clk);
            #1;
            check_val("pf_hold", 32'(rd_req), 32'd0);
        end
        check_val("pf_no_accept", 32'(acc_cnt - ab2), 32'd0);
        rfifo_prog_full = 1'b0;
        wait_done("done_deep", 600);
        check_val("wr_count_deep", 32'(wr_cnt - wb), 32'd32);
        check_val("peak_out", 32'(peak_out), 32'(MAX_OUT));

        // stray return while idle
        lat = 3;
        sp.due = cyc + 1;
        sp.d = 16'hBEEF;
        last_due = sp.due;
        ret_q.push_back(sp);
        repeat (4) @(posedge sdram_clk);
        #1;
        check_val("err_set", 32'(rd_err), 32'd1);
        repeat (5) @(posedge sdram_clk);
        #1;
        check_val("err_sticky", 32'(rd_err), 32'd1);
        start_rd(32'h200, 32'd2, 32'd1023);
        check_val("err_clear", 32'(rd_err), 32'd0);
        wait_done("done_after_err", 100);
        check_val("err_stays_clear", 32'(rd_err), 32'd0);

        // reset in the middle of a readback
        ab = acc_cnt;
        db = done_cnt;
        start_rd(32'h1000, 32'd16, 32'd1023);
        for (int i = 0; i < 100 && (acc_cnt - ab) < 5; i++) begin
            @(posedge sdram_clk);
            #1;
        end
        sdram_rst = 1'b1;
        exp_data.delete();
        model_out = 0;
        @(negedge sdram_clk);
        check_val("mid_rst_req", 32'(rd_req), 32'd0);
        check_val("mid_rst_addr", rd_addr, 32'd0);
        check_val("mid_rst_wr_en", 32'(rfifo_wr_en), 32'd0);
        check_val("mid_rst_busy", 32'(rd_busy), 32'd0);
        check_val("mid_rst_done", 32'(rd_done), 32'd0);
        @(posedge sdram_clk);
        #1 sdram_rst = 1'b0;
        exp_addr.delete();
        repeat (10) @(posedge sdram_clk);
        #1;
        check_val("rst_no_done", 32'(done_cnt - db), 32'd0);
        check_val("rst_late_err", 32'(rd_err), 32'd1);
        wb = wr_cnt;
        start_rd(32'h2000, 32'd6, 32'd1023);
        check_val("err_clear_after_rst", 32'(rd_err), 32'd0);
        wait_done("done_after_rst", 100);
        check_val("wr_count_after_rst", 32'(wr_cnt - wb), 32'd6);

        repeat (5) @(posedge sdram_clk);
        #1;
        check_val("data_q_empty", 32'(exp_data.size()), 32'd0);
        check_val("ret_q_empty", 32'(ret_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dread.md
DREAD -- requirements
Module: dread

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 8: maximum number of accepted but not yet returned SDRAM read words (range 1..15).
REQ-002 sdram_clk  input  1  sole clock; all logic on rising edge.
REQ-003 sdram_rst  input  1  asynchronous reset, active-high.
REQ-004 rd_start  input  1  single-cycle pulse that starts a readback.
REQ-005 rd_start_addr  input  32  first byte address; bits [1:0] are ignored and treated as 0.
REQ-006 rd_depth  input  32  number of 16-bit words to read.
REQ-007 sample_last_cnt  input  32  word index at which the address wraps.
REQ-008 rd_req  output  1  SDRAM read request.
REQ-009 rd_addr  output  32  SDRAM read byte address.
REQ-010 rd_valid  input  1  sdramc accepted the current rd_req/rd_addr.
REQ-011 rd_data_valid  input  1  rd_data is returned this cycle.
REQ-012 rd_data  input  16  returned SDRAM word.
REQ-013 rfifo_din  output  16  word to the host-side read FIFO.
REQ-014 rfifo_wr_en  output  1  write strobe to the host-side read FIFO.
REQ-015 rfifo_prog_full  input  1  host FIFO has fewer than MAX_OUTSTANDING+2 free slots.
REQ-016 rd_busy  output  1  high in any state other than IDLE.
REQ-017 rd_done  output  1  one-cycle pulse when a readback completes.
REQ-018 rd_err  output  1  sticky flag: rd_data_valid arrived while the outstanding count was 0.

Function
REQ-019 States: IDLE, REQ, DRAIN, DONE.
- IDLE->REQ on rd_start with rd_depth!=0.
- IDLE->DONE on rd_start with rd_depth==0.
REQ-020 On leaving IDLE via rd_start:
- rd_addr <= {rd_start_addr[31:2],2'b00}.
- remaining counter <= rd_depth.
REQ-021 rd_req SHALL be a registered output equal to (state==REQ) & ~rfifo_prog_full & (outstanding < MAX_OUTSTANDING).
REQ-022 When rd_req & rd_valid:
- rd_addr becomes 0 if rd_addr[31:2]==sample_last_cnt, else rd_addr+4.
- remaining decrements by 1.
- outstanding increments by 1.
REQ-023 When rd_data_valid, outstanding decrements by 1; an accept and a return in the same cycle leave outstanding unchanged.
REQ-024 REQ->DRAIN in the cycle the accept takes remaining from 1 to 0; rd_req is deasserted on the next cycle.
REQ-025 DRAIN->DONE when outstanding==0 and no return is pending this cycle.
REQ-026 DONE: rd_done=1 for exactly one cycle, then ->IDLE.
REQ-027 rd_start while rd_busy is ignored.
REQ-028 rfifo_din/rfifo_wr_en are rd_data/rd_data_valid registered, one cycle of latency, forwarded in every state regardless of rfifo_prog_full.
REQ-029 rd_err is set when rd_data_valid arrives with outstanding==0; it is cleared only by reset or by an accepted rd_start.
REQ-030 All counters are 32-bit unsigned except outstanding, which is 4-bit; outstanding never underflows (it saturates at 0 and rd_err flags the event).

Reset
REQ-031 Asserting sdram_rst at any time forces:
- state=IDLE.
- rd_req, rfifo_wr_en, rd_busy, rd_done, rd_err = 0.
- rd_addr, rfifo_din, remaining, outstanding = 0.
REQ-032 Reset mid-readback abandons the readback with no rd_done pulse; in-flight returns after reset release set rd_err.

Configuration
REQ-033 Macro DREAD_ABORT_EN defined:
- adds input rd_abort (1 bit).
- rd_abort in REQ clears remaining and moves to DRAIN; rd_req is low from the next cycle.
- rd_abort in IDLE, DRAIN or DONE has no effect.
- the readback then completes with the normal DONE pulse.
REQ-034 Macro DREAD_ABORT_EN undefined: no rd_abort port, and a readback always runs for rd_depth words.

Verification
REQ-035 rd_start_addr=0x100, rd_depth=4, sample_last_cnt=1023, rd_valid and return latency 3 -> rd_addr 0x100,0x104,0x108,0x10C; rfifo_wr_en pulses 4 times, each one cycle after its return; then one rd_done.
REQ-036 rd_start_addr=0xFF8 (word 1022), rd_depth=4, sample_last_cnt=1023 -> addresses 0xFF8,0xFFC,0x000,0x004.
REQ-037 rd_depth=0 -> rd_done exactly 2 cycles after rd_start; rd_req never asserted.
REQ-038 Return latency 20, MAX_OUTSTANDING=8, rd_depth=32 -> outstanding never exceeds 8; rd_req is low whenever outstanding is 8; rfifo_prog_full held high stops rd_req within 1 cycle; all 32 words are delivered.
REQ-039 Spurious rd_data_valid in IDLE -> rd_err=1 and stays set; the next rd_start clears it.
REQ-040 sdram_rst pulsed after 5 of 16 words accepted -> all outputs 0 next cycle; no rd_done; a subsequent readback runs correctly.
